// File: rtl/gate_actuator_ctrl_if.sv
// Handshake bundle between the level-crossing logic / barrier switches and the
// gate actuator controller.
interface gate_actuator_ctrl_if;
    logic       gate_open;
    logic       lim_up;
    logic       lim_down;
    logic       motor_up;
    logic       motor_down;
    logic       warn_lamp;
    logic       buzzer;
    logic       fault;
    logic [2:0] gate_state;

    modport master (
        output gate_open, lim_up, lim_down,
        input  motor_up, motor_down, warn_lamp, buzzer, fault, gate_state
    );

    modport slave (
        input  gate_open, lim_up, lim_down,
        output motor_up, motor_down, warn_lamp, buzzer, fault, gate_state
    );
endinterface

// File: rtl/gate_actuator_ctrl.sv
// Barrier sequencer: warn -> lower -> closed -> hold -> raise, with limit-switch
// supervision, motion timeouts and a latched fault that only Reset clears.
module gate_actuator_ctrl #(
    parameter int WARN_CYCLES  = 8,
    parameter int MOVE_TIMEOUT = 16,
    parameter int CLR_CYCLES   = 4,
    parameter int FLASH_DIV    = 4,
    parameter int TW           = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    gate_actuator_ctrl_if.slave io
);

    typedef enum logic [2:0] {
        ST_OPEN     = 3'd0,
        ST_WARN     = 3'd1,
        ST_LOWERING = 3'd2,
        ST_CLOSED   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RAISING  = 3'd5,
        ST_FAULT    = 3'd6
    } state_e;

    localparam logic [TW-1:0] WARN_LAST  = TW'(WARN_CYCLES - 1);
    localparam logic [TW-1:0] MOVE_LAST  = TW'(MOVE_TIMEOUT - 1);
    localparam logic [TW-1:0] CLR_LAST   = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_DIV - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] fcnt_q, fcnt_d;
    logic          flash_q, flash_d;
    logic          motor_up_q, motor_up_d;
    logic          motor_down_q, motor_down_d;
    logic          warn_lamp_q, warn_lamp_d;
    logic          buzzer_q, buzzer_d;
    logic          fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        if (io.lim_up && io.lim_down) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_OPEN:     if (!io.gate_open) state_d = ST_WARN;
                ST_WARN:     if (io.gate_open) state_d = ST_OPEN;
                             else if (timer_q == WARN_LAST) state_d = ST_LOWERING;
                ST_LOWERING: if (io.lim_down) state_d = ST_CLOSED;
                             else if (timer_q == MOVE_LAST) state_d = ST_FAULT;
                ST_CLOSED:   if (io.gate_open) state_d = ST_HOLD;
                ST_HOLD:     if (!io.gate_open) state_d = ST_CLOSED;
                             else if (timer_q == CLR_LAST) state_d = ST_RAISING;
                // Re-closing outranks reaching the top: a train may arrive mid-raise.
                ST_RAISING:  if (!io.gate_open) state_d = ST_LOWERING;
                             else if (io.lim_up) state_d = ST_OPEN;
                             else if (timer_q == MOVE_LAST) state_d = ST_FAULT;
                ST_FAULT:    state_d = ST_FAULT;
                default:     state_d = ST_FAULT;
            endcase
        end

        timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;

        // Parked at phase start while OPEN so every closing cycle begins lamp-on.
        fcnt_d  = fcnt_q;
        flash_d = flash_q;
        if (state_q == ST_OPEN) begin
            fcnt_d  = '0;
            flash_d = 1'b1;
        end else if (state_q != ST_FAULT) begin
            if (fcnt_q == FLASH_LAST) begin
                fcnt_d  = '0;
                flash_d = ~flash_q;
            end else begin
                fcnt_d  = fcnt_q + 1'b1;
            end
        end

        // Outputs are decoded one edge early so they land registered with the state.
        motor_up_d   = 1'b0;
        motor_down_d = 1'b0;
        warn_lamp_d  = 1'b0;
        buzzer_d     = 1'b0;
        fault_d      = 1'b0;
        case (state_d)
            ST_WARN:     begin buzzer_d = 1'b1; warn_lamp_d = flash_d; end
            ST_LOWERING: begin motor_down_d = 1'b1; buzzer_d = 1'b1; warn_lamp_d = flash_d; end
            ST_CLOSED,
            ST_HOLD:     warn_lamp_d = flash_d;
            ST_RAISING:  begin motor_up_d = 1'b1; warn_lamp_d = flash_d; end
            ST_FAULT:    begin warn_lamp_d = 1'b1; buzzer_d = 1'b1; fault_d = 1'b1; end
            default:     ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_OPEN;
            timer_q      <= '0;
            fcnt_q       <= '0;
            flash_q      <= 1'b1;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            warn_lamp_q  <= 1'b0;
            buzzer_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fcnt_q       <= fcnt_d;
            flash_q      <= flash_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            warn_lamp_q  <= warn_lamp_d;
            buzzer_q     <= buzzer_d;
            fault_q      <= fault_d;
        end
    end

    assign io.motor_up   = motor_up_q;
    assign io.motor_down = motor_down_q;
    assign io.warn_lamp  = warn_lamp_q;
    assign io.buzzer     = buzzer_q;
    assign io.fault      = fault_q;
    assign io.gate_state = state_q;

endmodule

// File: tb/tb_gate_actuator_ctrl.sv
// Bench for gate_actuator_ctrl: directed sequences plus random stimulus, all
// compared every cycle against a rule-level reference model.
module tb_gate_actuator_ctrl;
    localparam int WARN_CYCLES  = 8;
    localparam int MOVE_TIMEOUT = 16;
    localparam int CLR_CYCLES   = 4;
    localparam int FLASH_DIV    = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    gate_actuator_ctrl_if io();

    gate_actuator_ctrl #(
        .WARN_CYCLES(WARN_CYCLES), .MOVE_TIMEOUT(MOVE_TIMEOUT),
        .CLR_CYCLES(CLR_CYCLES), .FLASH_DIV(FLASH_DIV), .TW(16)
    ) dut (
        .Clk(Clk), .Reset(Reset), .io(io.slave)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Model: state code, cycles spent in that state, cycles since leaving OPEN.
    int m_st, m_tmr, m_ph;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_st = 0; m_tmr = 0; m_ph = 0;
    endfunction

    function automatic void m_step(bit g, bit u, bit d);
        int nx;
        case (m_st)
            0: nx = g ? 0 : 1;
            1: nx = g ? 0 : (m_tmr == WARN_CYCLES - 1 ? 2 : 1);
            2: nx = d ? 3 : (m_tmr == MOVE_TIMEOUT - 1 ? 6 : 2);
            3: nx = g ? 4 : 3;
            4: nx = !g ? 3 : (m_tmr == CLR_CYCLES - 1 ? 5 : 4);
            5: nx = !g ? 2 : (u ? 0 : (m_tmr == MOVE_TIMEOUT - 1 ? 6 : 5));
            default: nx = 6;
        endcase
        if (u && d) nx = 6;
        if (m_st == 0 && nx != 0) m_ph = 0;
        else if (m_st != 0) m_ph++;
        m_tmr = (nx == m_st) ? m_tmr + 1 : 0;
        m_st = nx;
    endfunction

    // {gate_state, motor_up, motor_down, warn_lamp, buzzer, fault}
    function automatic logic [7:0] m_out();
        logic lamp;
        if (m_st == 6)      lamp = 1'b1;
        else if (m_st == 0) lamp = 1'b0;
        else                lamp = ((m_ph / FLASH_DIV) % 2) == 0;
        return {3'(m_st), m_st == 5, m_st == 2, lamp,
                (m_st == 1 || m_st == 2 || m_st == 6), m_st == 6};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {io.gate_state, io.motor_up, io.motor_down, io.warn_lamp, io.buzzer, io.fault};
    endfunction

    always @(negedge Clk) begin
        if (chk_en) chk("cycle_outputs", 32'(dut_vec()), 32'(m_out()));
    end

    task automatic cyc(bit g, bit u, bit d);
        io.gate_open = g; io.lim_up = u; io.lim_down = d;
        @(posedge Clk);
        if (Reset) m_reset(); else m_step(g, u, d);
        @(negedge Clk);
    endtask

    // Called right after a cyc, i.e. mid low phase, so no edge is skipped.
    task automatic async_reset();
        #2;
        Reset = 1'b1;
        m_reset();
        #1;
        chk("async_reset_clear", 32'(dut_vec()), 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic to_closed();
        repeat (9) cyc(0, 0, 0);
        cyc(0, 0, 1);
    endtask

    initial begin
        logic [7:0] pat;
        int cnt;
        bit g;
        int fault_cycles;

        io.gate_open = 1'b1; io.lim_up = 1'b0; io.lim_down = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_outputs", 32'(dut_vec()), 32'h0);
        Reset = 1'b0;
        m_reset();
        chk_en = 1;

        repeat (20) cyc(1, 0, 0);
        chk("open_idle_state", 32'(io.gate_state), 32'd0);

        pat = '0; cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0);
            pat = {pat[6:0], io.warn_lamp};
            cnt += int'(io.buzzer);
        end
        chk("warn_lamp_pattern", 32'(pat), 32'h0F0);
        chk("warn_buzzer_cycles", 32'(cnt), 32'd8);
        chk("warn_state_last", 32'(io.gate_state), 32'd1);

        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            cnt += int'(io.motor_down);
        end
        chk("lowering_md_cycles", 32'(cnt), 32'd5);
        cyc(0, 0, 1);
        chk("closed_outputs", 32'(dut_vec()), {24'h0, 3'd3, 1'b0, 1'b0, io.warn_lamp, 1'b0, 1'b0});
        chk("closed_state", 32'(io.gate_state), 32'd3);

        cyc(1, 0, 0); cyc(1, 0, 0);
        chk("hold_entered", 32'(io.gate_state), 32'd4);
        cyc(0, 0, 0);
        chk("hold_to_closed", 32'(io.gate_state), 32'd3);
        cyc(1, 0, 0);
        repeat (3) cyc(1, 0, 0);
        chk("hold_before_raise", 32'(io.gate_state), 32'd4);
        cyc(1, 0, 0);
        chk("raising_entered", 32'({io.gate_state, io.motor_up}), {28'h0, 3'd5, 1'b1});
        cyc(1, 1, 0);
        chk("lim_up_open", 32'(io.gate_state), 32'd0);

        cnt = 0;
        repeat (4) begin cyc(0, 0, 0); cnt += int'(io.motor_down); end
        chk("warn_timer3_state", 32'(io.gate_state), 32'd1);
        cyc(1, 0, 0);
        cnt += int'(io.motor_down);
        chk("warn_abort_open", 32'(io.gate_state), 32'd0);
        chk("warn_abort_no_motion", 32'(cnt), 32'd0);

        to_closed();
        repeat (5) cyc(1, 0, 0);
        chk("reclose_in_raising", 32'(io.gate_state), 32'd5);
        cyc(0, 1, 0);
        chk("reclose_wins", 32'({io.gate_state, io.motor_up, io.motor_down}), {27'h0, 3'd2, 1'b0, 1'b1});
        cyc(0, 0, 1);

        repeat (5) cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (9) cyc(0, 0, 0);
        repeat (15) cyc(0, 0, 0);
        chk("lowering_16th_cycle", 32'(io.gate_state), 32'd2);
        cyc(0, 0, 0);
        chk("lowering_timeout_fault", 32'(dut_vec()), 32'hC7);
        for (int i = 0; i < 6; i++) cyc(i[0], 0, 0);
        chk("fault_latched", 32'(io.gate_state), 32'd6);
        async_reset();

        cyc(1, 1, 1);
        chk("both_limits_fault", 32'(io.gate_state), 32'd6);
        async_reset();

        g = 1'b1; fault_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            bit d, u;
            if ($urandom_range(9) == 0) g = ~g;
            d = ($urandom_range(4) == 0);
            u = ($urandom_range(4) == 0) && !(d && $urandom_range(7) != 0);
            cyc(g, u, d);
            fault_cycles = (m_st == 6) ? fault_cycles + 1 : 0;
            if (fault_cycles > 3) begin
                async_reset();
                fault_cycles = 0;
            end
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
